// File: rtl/imem_loader.sv
// imem_loader: UART program loader that writes little-endian 32-bit words into instruction memory.
// Define LOADER_CSUM_EN to expect and verify a trailing XOR checksum byte.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic              core_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    WAIT_SYNC, LEN_LO, LEN_HI, DATA, ERROR
`ifdef LOADER_CSUM_EN
    , CSUM
`endif
  } ld_state_t;

  rx_state_t        r_rx_st, w_rx_nxt;
  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_shift;
  logic             w_byte_vld, w_frame_err, w_cnt_wrap;

  // RX front end: start-bit qualification at half bit, then full-bit sampling
  always_comb begin
    w_rx_nxt    = r_rx_st;
    w_byte_vld  = 1'b0;
    w_frame_err = 1'b0;
    w_cnt_wrap  = 1'b0;
    case (r_rx_st)
      RX_IDLE:  if (r_rx_s3 && !r_rx_s2) w_rx_nxt = RX_START;
      RX_START: if (r_rx_cnt == HALF_M1) begin
        w_cnt_wrap = 1'b1;
        w_rx_nxt   = r_rx_s2 ? RX_IDLE : RX_BITS;
      end
      RX_BITS:  if (r_rx_cnt == FULL_M1) begin
        w_cnt_wrap = 1'b1;
        if (r_bit_idx == 3'd7) w_rx_nxt = RX_STOP;
      end
      RX_STOP:  if (r_rx_cnt == FULL_M1) begin
        w_cnt_wrap  = 1'b1;
        w_rx_nxt    = RX_IDLE;
        w_byte_vld  = r_rx_s2;
        w_frame_err = !r_rx_s2;
      end
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_st   <= RX_IDLE;
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_s3   <= 1'b1;
      r_rx_cnt  <= '0;
      r_bit_idx <= '0;
    end else begin
      r_rx_st <= w_rx_nxt;
      r_rx_s1 <= rx_in;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (r_rx_st == RX_IDLE || w_cnt_wrap) r_rx_cnt <= '0;
      else                                  r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_st == RX_START)                  r_bit_idx <= '0;
      else if (r_rx_st == RX_BITS && w_cnt_wrap) r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_rx_st == RX_BITS && w_cnt_wrap) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
  end

  ld_state_t        r_ld_st, w_ld_nxt;
  logic             r_hold, r_err, r_done, r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]      r_wr_data;
  logic [15:0]      r_wcnt, r_len;
  logic [7:0]       r_len_lo;
  logic [23:0]      r_word;
  logic [1:0]       r_bidx;
  logic [15:0]      w_len;
  logic             w_is_sync, w_too_big, w_last_word, w_start, w_finish, w_fail, w_wr;
`ifdef LOADER_CSUM_EN
  logic [7:0]       r_csum;
`else
  logic             r_fin;
`endif

  assign w_len       = {r_rx_shift, r_len_lo};
  assign w_is_sync   = w_byte_vld && (r_rx_shift == 8'hA5);
  assign w_too_big   = {1'b0, w_len} > (17'd1 << ADDR_W);
  assign w_wr        = (r_ld_st == DATA) && w_byte_vld && (r_bidx == 2'd3);
  assign w_last_word = w_wr && (r_wcnt + 16'd1 == r_len);

  // Loader FSM: next-state only; datapath side effects keyed off transitions
  always_comb begin
    w_ld_nxt = r_ld_st;
    case (r_ld_st)
      WAIT_SYNC, ERROR: if (w_is_sync) w_ld_nxt = LEN_LO;
      LEN_LO: begin
        if (w_frame_err)     w_ld_nxt = ERROR;
        else if (w_byte_vld) w_ld_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (w_frame_err) w_ld_nxt = ERROR;
        else if (w_byte_vld) begin
          if (w_too_big)          w_ld_nxt = ERROR;
          else if (w_len == 16'd0)
`ifdef LOADER_CSUM_EN
            w_ld_nxt = CSUM;
`else
            w_ld_nxt = WAIT_SYNC;
`endif
          else                    w_ld_nxt = DATA;
        end
      end
      DATA: begin
        if (w_frame_err)      w_ld_nxt = ERROR;
`ifdef LOADER_CSUM_EN
        else if (w_last_word) w_ld_nxt = CSUM;
`else
        else if (r_fin)       w_ld_nxt = WAIT_SYNC;
`endif
      end
`ifdef LOADER_CSUM_EN
      CSUM: begin
        if (w_frame_err)     w_ld_nxt = ERROR;
        else if (w_byte_vld) w_ld_nxt = (r_rx_shift == r_csum) ? WAIT_SYNC : ERROR;
      end
`endif
      default: w_ld_nxt = WAIT_SYNC;
    endcase
  end

  assign w_start  = w_is_sync && (r_ld_st == WAIT_SYNC || r_ld_st == ERROR);
  assign w_finish = (r_ld_st != WAIT_SYNC) && (r_ld_st != ERROR) && (w_ld_nxt == WAIT_SYNC);
  assign w_fail   = (r_ld_st != ERROR) && (w_ld_nxt == ERROR);

  always_ff @(posedge clk) begin
    if (reset) r_ld_st <= WAIT_SYNC;
    else       r_ld_st <= w_ld_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wcnt    <= '0;
      r_bidx    <= '0;
`ifndef LOADER_CSUM_EN
      r_fin     <= 1'b0;
`endif
    end else begin
      r_done  <= w_finish;
      r_wr_en <= w_wr;
      if (w_start) begin
        r_hold <= 1'b1;
        r_err  <= 1'b0;
        r_wcnt <= '0;
        r_bidx <= '0;
      end
      if (w_finish) r_hold <= 1'b0;
      if (w_fail)   r_err  <= 1'b1;
      if (r_ld_st == DATA && w_byte_vld) r_bidx <= r_bidx + 1'b1;
      if (w_wr) begin
        r_wr_addr <= r_wcnt[ADDR_W-1:0];
        r_wr_data <= {r_rx_shift, r_word};
        r_wcnt    <= r_wcnt + 16'd1;
      end
`ifndef LOADER_CSUM_EN
      // Defers completion one cycle so done follows the final write strobe
      r_fin <= w_last_word;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (r_ld_st == LEN_LO && w_byte_vld) r_len_lo <= r_rx_shift;
    if (r_ld_st == LEN_HI && w_byte_vld) r_len    <= w_len;
    if (r_ld_st == DATA && w_byte_vld)   r_word   <= {r_rx_shift, r_word[23:8]};
`ifdef LOADER_CSUM_EN
    if (w_start)                         r_csum <= '0;
    else if (r_ld_st == DATA && w_byte_vld) r_csum <= r_csum ^ r_rx_shift;
`endif
  end

  assign core_hold  = r_hold;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_wcnt;
endmodule
